imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_loader_byte_packer.sv | 45 ++++
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: FSM state encoding,
// frame field widths and the default program-length limit.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int LEN_W         = 16;   // length field width (two bytes)
    localparam int BYTE_W        = 8;    // stream byte width
    localparam int WORD_W        = 32;   // instruction word width
    localparam int DEF_MAX_WORDS = 256;  // default largest program, in words

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    // States in which a load is in progress and the byte stream is consumed.
    function automatic logic is_busy(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Assembles four bytes into one big-endian 32-bit word (first byte -> 31:24).
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clr          synchronous clear of the partial word and byte counter
//   accept       a byte is consumed this cycle
//   byte_in      the byte being consumed
//   word         assembled word including byte_in (valid when word_rdy)
//   word_rdy     this accept completes a word (4th byte)
// ---------------------------------------------------------------------------
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                accept,
    input  logic [BYTE_W-1:0]   byte_in,
    output logic [WORD_W-1:0]   word,
    output logic                word_rdy
);

    logic [WORD_W-BYTE_W-1:0] r_shift;  // first three bytes of the word
    logic [1:0]               r_cnt;    // bytes already held in r_shift

    // The word is presented combinationally so the parent can register it on
    // the same edge that consumes the last byte; no extra cycle is lost.
    assign word     = {r_shift, byte_in};
    assign word_rdy = accept && (r_cnt == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_cnt   <= 2'd0;
        end else if (clr) begin
            r_shift <= '0;
            r_cnt   <= 2'd0;
        end else if (accept) begin
            r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], byte_in};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Receives a framed program over a byte stream and writes it into
// instruction memory while holding the CPU in reset.
// Frame: length N (16-bit big-endian), 4N data bytes (big-endian words),
// one checksum byte = XOR of all length and data bytes.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 pulse to begin a load (ignored while busy)
//   rx_valid/rx_data      byte source
//   rx_ready              loader accepts a byte
//   wr_en/wr_addr/wr_data instruction-memory write, one cycle per word
//   cpu_reset             low only after a good load
//   busy, done, err       load status
//   word_count            words written in the current/last load
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = DEF_MAX_WORDS,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [31:0]       wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  word_count
);

    localparam logic [LEN_W:0] LP_MAX = (LEN_W+1)'(MAX_WORDS);

    state_t              r_state, w_next;
    logic [LEN_W-1:0]    r_len;
    logic [BYTE_W-1:0]   r_csum;
    logic                r_wr_en;
    logic [31:0]         r_wr_addr;
    logic [WORD_W-1:0]   r_wr_data;
    logic [LEN_W-1:0]    r_word_count;

    logic                w_busy;
    logic                w_acc;
    logic                w_start_ok;
    logic [LEN_W-1:0]    w_len;
    logic                w_last_word;
    logic [WORD_W-1:0]   w_word;
    logic                w_word_rdy;

    assign w_len       = {r_len[LEN_W-1:BYTE_W], rx_data};
    assign w_last_word = ((r_word_count + 16'd1) == r_len);
    assign w_busy      = is_busy(r_state);
    assign w_acc       = rx_valid && w_busy;
    assign w_start_ok  = start && !w_busy;

    byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_start_ok),
        .accept   (w_acc && (r_state == DATA)),
        .byte_in  (rx_data),
        .word     (w_word),
        .word_rdy (w_word_rdy)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERROR: if (start) w_next = LEN_HI;
            LEN_HI: if (rx_valid) w_next = LEN_LO;
            LEN_LO: begin
                if (rx_valid) begin
                    if (w_len == '0)                w_next = CSUM;
                    else if ({1'b0, w_len} > LP_MAX) w_next = ERROR;
                    else                            w_next = DATA;
                end
            end
            // Leaving for CSUM on the last data byte lets the checksum byte
            // be taken during the final write cycle.
            DATA:   if (rx_valid && w_word_rdy && w_last_word) w_next = CSUM;
            CSUM:   if (rx_valid) w_next = (rx_data == r_csum) ? DONE : ERROR;
            default: w_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len        <= '0;
            r_csum       <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= BASE_ADDR;
            r_wr_data    <= '0;
            r_word_count <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start_ok) begin
                r_word_count <= '0;
                r_csum       <= '0;
            end
            if (w_acc) begin
                case (r_state)
                    LEN_HI: begin
                        r_len[LEN_W-1:BYTE_W] <= rx_data;
                        r_csum                <= r_csum ^ rx_data;
                    end
                    LEN_LO: begin
                        r_len  <= w_len;
                        r_csum <= r_csum ^ rx_data;
                    end
                    DATA: begin
                        r_csum <= r_csum ^ rx_data;
                        if (w_word_rdy) begin
                            r_wr_en      <= 1'b1;
                            r_wr_addr    <= BASE_ADDR + {14'd0, r_word_count, 2'b00};
                            r_wr_data    <= w_word;
                            r_word_count <= r_word_count + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_ready   = w_busy;
    assign busy       = w_busy;
    assign cpu_reset  = (r_state != DONE);
    assign done       = (r_state == DONE);
    assign err        = (r_state == ERROR);
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int          MAXW = 256;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, wr_en, cpu_reset, busy, done, err;
    logic [31:0] wr_addr, wr_data;
    logic [15:0] word_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic        prev_wr = 1'b0;

    imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_ready(rx_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .cpu_reset(cpu_reset),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xor_bytes(input logic [7:0] q[$]);
        logic [7:0] x = 8'h00;
        foreach (q[i]) x ^= q[i];
        return x;
    endfunction

    // Per-cycle checker: every write must match the next expected write.
    always @(negedge clk) begin
        if (reset) begin
            prev_wr = 1'b0;
        end else begin
            check("cpu_reset_vs_done", 32'(cpu_reset), 32'(!done));
            check("busy_vs_rx_ready", 32'(busy), 32'(rx_ready));
            check("done_and_err", 32'(done & err), 32'd0);
            if (wr_en) begin
                check("wr_en_back_to_back", 32'(prev_wr), 32'd0);
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h with none expected", wr_addr, wr_data);
                end else begin
                    check("wr_addr", wr_addr, exp_addr_q.pop_front());
                    check("wr_data", wr_data, exp_data_q.pop_front());
                end
            end
            prev_wr = wr_en;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
        check({tag, "_wr_en"},      32'(wr_en),      32'd0);
        check({tag, "_wr_addr"},    wr_addr,         BASE);
        check({tag, "_wr_data"},    wr_data,         32'd0);
        check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one byte and hold it until it is taken (bounded).
    task automatic send_byte(input logic [7:0] b, input bit gappy, input bit inj);
        int n;
        if (gappy)
            while ($urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0;
                @(posedge clk); #1;
            end
        rx_valid = 1'b1;
        rx_data  = b;
        start    = inj && ($urandom_range(0, 3) == 0);
        n = 0;
        while (!rx_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL rx_timeout: rx_ready stayed 0, wanted 1");
        end else begin
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // Build a frame, predict its writes/status, drive it and check the result.
    task automatic run_frame(input int n, input bit bad, input bit gappy,
                             input bit inj, input logic [31:0] wq[$]);
        logic [7:0]  bytes[$];
        logic [7:0]  cs;
        logic [15:0] len;
        logic [31:0] w;
        bit          ok;
        len = 16'(n);
        bytes.push_back(len[15:8]);
        bytes.push_back(len[7:0]);
        if (n <= MAXW)
            for (int i = 0; i < n; i++) begin
                w = (i < wq.size()) ? wq[i] : $urandom;
                exp_addr_q.push_back(BASE + 32'(4 * i));
                exp_data_q.push_back(w);
                bytes.push_back(w[31:24]);
                bytes.push_back(w[23:16]);
                bytes.push_back(w[15:8]);
                bytes.push_back(w[7:0]);
            end
        cs = xor_bytes(bytes);
        if (bad) cs ^= 8'(1 << $urandom_range(0, 7));
        ok = (n <= MAXW) && !bad;

        pulse_start();
        if (n > MAXW) begin
            send_byte(bytes[0], gappy, inj);
            send_byte(bytes[1], gappy, inj);
        end else begin
            foreach (bytes[i]) send_byte(bytes[i], gappy, inj);
            send_byte(cs, gappy, inj);
        end
        rx_valid = 1'b0;
        @(posedge clk); #1;

        check("end_done",       32'(done),       32'(ok));
        check("end_err",        32'(err),        32'(!ok));
        check("end_cpu_reset",  32'(cpu_reset),  32'(!ok));
        check("end_busy",       32'(busy),       32'd0);
        check("end_rx_ready",   32'(rx_ready),   32'd0);
        check("end_word_count", 32'(word_count), (n <= MAXW) ? 32'(n) : 32'd0);
        check("writes_pending", 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] wq[$];
        logic [31:0] none[$];
        logic [7:0]  pin[$];

        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #3;
        check_reset_vals("por");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Reference frame: checksum of its bytes is 0xAD.
        pin = '{8'h00, 8'h02, 8'h20, 8'h10, 8'h00, 8'h05, 8'h02, 8'h30, 8'h88, 8'h20};
        check("model_csum_pin", 32'(xor_bytes(pin)), 32'h0000_00AD);
        wq = '{32'h2010_0005, 32'h0230_8820};

        run_frame(2, 1'b0, 1'b0, 1'b0, wq);
        check("lit_word_count", 32'(word_count), 32'd2);
        check("lit_last_addr",  wr_addr,         32'h0000_0004);
        check("lit_last_data",  wr_data,         32'h0230_8820);
        check("lit_cpu_reset",  32'(cpu_reset),  32'd0);

        run_frame(2, 1'b1, 1'b0, 1'b0, wq);          // bad checksum, writes kept
        check("lit_bad_err", 32'(err), 32'd1);

        run_frame(257, 1'b0, 1'b0, 1'b0, none);      // over-length
        run_frame(0, 1'b0, 1'b0, 1'b0, none);        // empty program
        run_frame(2, 1'b0, 1'b1, 1'b1, wq);          // stalls + start mid-load
        check("lit_gappy_wc", 32'(word_count), 32'd2);

        // Reset after two data bytes: abort, no partial write.
        pulse_start();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h20, 1'b0, 1'b0);
        send_byte(8'h10, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        rx_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_frame(2, 1'b0, 1'b0, 1'b0, wq);

        for (int k = 0; k < 12; k++)
            run_frame($urandom_range(0, 6), ($urandom_range(0, 3) == 0),
                      bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), none);
        run_frame(MAXW + 1 + $urandom_range(0, 100), 1'b0, 1'b1, 1'b0, none);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
